// File: rtl/vec_dot_pkg.sv
// Shared definitions for the dot-product CSR front-end: register map, CTRL bit
// positions, run-sequencing states and the byte-lane merge helper.
package vec_dot_pkg;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_LENGTH    = 3'd1;
    localparam logic [2:0] REG_VECA_BASE = 3'd2;
    localparam logic [2:0] REG_VECB_BASE = 3'd3;
    localparam logic [2:0] REG_RESULT_LO = 3'd4;
    localparam logic [2:0] REG_RESULT_HI = 3'd5;
    localparam logic [2:0] REG_CYCLES    = 3'd6;
    localparam logic [2:0] REG_VERSION   = 3'd7;

    // CTRL write-side bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_CLR_DONE = 2;
    localparam int CTRL_CLR_ERR  = 3;

    // CTRL read-side bits (irq_en reads back at CTRL_IRQ_EN)
    localparam int CTRL_BUSY = 0;
    localparam int CTRL_DONE = 2;
    localparam int CTRL_ERR  = 3;

    localparam logic [31:0] VERSION_DEFAULT = 32'h0D07_0001;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RUNNING
    } state_t;

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/vec_dot_csr_slave.sv
// Avalon-MM register front-end for the dot-product core: holds the run
// configuration, launches runs, snapshots result and busy-cycle count, raises irq.
module vec_dot_csr_slave
    import vec_dot_pkg::*;
#(
    parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic        core_start,
    output logic [31:0] core_length,
    output logic [31:0] core_vecA_baseAddr,
    output logic [31:0] core_vecB_baseAddr,
    input  logic        core_busy,
    input  logic [63:0] core_result
);

    state_t      state_q;
    logic [31:0] length_q;
    logic [31:0] veca_q;
    logic [31:0] vecb_q;
    logic [63:0] result_q;
    logic [31:0] cycles_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        done_q;
    logic        err_q;
    logic        irq_en_q;
    logic        start_q;
    logic [31:0] readdata_q;
    logic [31:0] readdata_d;
    logic [31:0] ctrl_rd;

    logic idle;
    logic ctrl_wr;
    logic cfg_wr;
    logic start_req;
    logic clr_done_req;
    logic clr_err_req;

    assign idle    = (state_q == IDLE);
    // CTRL fields all live in byte lane 0, so that lane gates the whole write.
    assign ctrl_wr = avs_write && (avs_address == REG_CTRL) && avs_byteenable[0];
    assign cfg_wr  = avs_write && ((avs_address == REG_LENGTH) ||
                                   (avs_address == REG_VECA_BASE) ||
                                   (avs_address == REG_VECB_BASE));

    assign start_req    = ctrl_wr && avs_writedata[CTRL_START];
    assign clr_done_req = ctrl_wr && avs_writedata[CTRL_CLR_DONE];
    assign clr_err_req  = ctrl_wr && avs_writedata[CTRL_CLR_ERR];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        cnt_d   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        ctrl_rd = '0;
        ctrl_rd[CTRL_BUSY]   = !idle;
        ctrl_rd[CTRL_IRQ_EN] = irq_en_q;
        ctrl_rd[CTRL_DONE]   = done_q;
        ctrl_rd[CTRL_ERR]    = err_q;

        readdata_d = '0;
        case (avs_address)
            REG_CTRL:      readdata_d = ctrl_rd;
            REG_LENGTH:    readdata_d = length_q;
            REG_VECA_BASE: readdata_d = veca_q;
            REG_VECB_BASE: readdata_d = vecb_q;
            REG_RESULT_LO: readdata_d = result_q[31:0];
            REG_RESULT_HI: readdata_d = result_q[63:32];
            REG_CYCLES:    readdata_d = cycles_q;
            REG_VERSION:   readdata_d = VERSION;
            default:       readdata_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            length_q   <= '0;
            veca_q     <= '0;
            vecb_q     <= '0;
            result_q   <= '0;
            cycles_q   <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            start_q    <= 1'b0;
            readdata_q <= '0;
        end else begin
            start_q <= 1'b0;

            if (avs_read) begin
                readdata_q <= readdata_d;
            end

            if (ctrl_wr) begin
                irq_en_q <= avs_writedata[CTRL_IRQ_EN];
            end

            // Configuration is frozen outside IDLE so the core sees stable inputs.
            if (cfg_wr && idle) begin
                case (avs_address)
                    REG_LENGTH:    length_q <= merge_be(length_q, avs_writedata, avs_byteenable);
                    REG_VECA_BASE: veca_q   <= merge_be(veca_q, avs_writedata, avs_byteenable);
                    REG_VECB_BASE: vecb_q   <= merge_be(vecb_q, avs_writedata, avs_byteenable);
                    default: ;
                endcase
            end

            // Clears come first; any set later in this block overrides them.
            if (clr_done_req) begin
                done_q <= 1'b0;
            end
            if (clr_err_req) begin
                err_q <= 1'b0;
            end
            if ((cfg_wr || start_req) && !idle) begin
                err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        state_q <= LAUNCH;
                        start_q <= 1'b1;
                    end
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (core_busy) begin
                        cnt_q   <= 32'd1;
                        state_q <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (core_busy) begin
                        cnt_q <= cnt_d;
                    end else begin
                        result_q <= core_result;
                        cycles_q <= cnt_q;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign avs_readdata       = readdata_q;
    assign irq                = done_q & irq_en_q;
    assign core_start         = start_q;
    assign core_length        = length_q;
    assign core_vecA_baseAddr = veca_q;
    assign core_vecB_baseAddr = vecb_q;

endmodule
